sdio_spi_bridge: RTL and testbench

- Zorro II slave for the SDIO card function. It consumes BASE_SDIO and SDIO_CONFIGURED_n from the autoconfig stage.
- Decodes 68000 bus cycles in the configured 64 KB window and generates its own DTACK, merged by the top level into DTACK_CPU_n.
- Exposes a byte-wide register set on the upper data lane D[15:8], driving an SPI-mode SD card.
- A single-byte SPI shift engine inserts wait states (withheld DTACK) while busy.

---
 rtl/sdio_spi_bridge.sv | 190 +++++++++++++++++++
 tb/tb_sdio_spi_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_spi_bridge.sv
// Zorro II slave for the SDIO function: byte-wide register window on D[15:8]
// driving an SPI-mode SD card, with wait states while the shift engine is busy.
`timescale 1ns/1ps
module sdio_spi_bridge #(
   parameter int unsigned DIV_RESET   = 62,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       C50M,
   input  logic       RESET_n,
   input  logic [7:0] A_HIGH,
   input  logic [2:0] A_LOW,
   input  logic       AS_CPU_n,
   input  logic       UDS_n,
   input  logic       LDS_n,
   input  logic       RW_n,
   input  logic [7:0] D_IN,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   input  logic [7:0] BASE_SDIO,
   input  logic       SDIO_CONFIGURED_n,
   output logic       SDIO_ACCESS,
   output logic       SDIO_DTACK_n,
   output logic       SD_SCLK,
   output logic       SD_MOSI,
   input  logic       SD_MISO,
   output logic       SD_CS_n,
   input  logic       SD_CD_n
);

   typedef enum logic [1:0] {B_IDLE, B_WAIT, B_EXEC, B_ACK} bus_state_t;
   typedef enum logic [1:0] {E_IDLE, E_LOW, E_HIGH} eng_state_t;

   bus_state_t bus_q, bus_d;
   eng_state_t eng_q, eng_d;
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_d [SYNC_STAGES];
   logic [7:0] dout_q, dout_d, div_q, div_d, rx_q, rx_d, shift_q, shift_d, cnt_q, cnt_d;
   logic [3:0] bits_q, bits_d;
   logic       cs_q, cs_d, fast_q, fast_d, sclk_q, sclk_d, mosi_q, mosi_d, samp_q, samp_d;
   logic       as_s, uds_s, lds_s, cd_s, win_hit, start_cond, eng_busy, needs_idle;
   logic       start_xfer;
   logic [7:0] start_tx, half_len;

   always_comb begin
      sync_d[0] = {SD_CD_n, LDS_n, UDS_n, AS_CPU_n};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   assign {cd_s, lds_s, uds_s, as_s} = sync_q[SYNC_STAGES-1];
   assign win_hit     = !SDIO_CONFIGURED_n && (A_HIGH == BASE_SDIO);
   assign SDIO_ACCESS = win_hit && !AS_CPU_n;
   assign start_cond  = !as_s && (!uds_s || !lds_s) && win_hit;
   assign eng_busy    = (eng_q != E_IDLE);
   assign half_len    = fast_q ? 8'd0 : div_q;

   // Accesses that would start the engine or retune it must wait for idle.
   assign needs_idle = !uds_s && (((A_LOW == 3'd0) && !RW_n) || ((A_LOW == 3'd3) && RW_n) ||
                                  (((A_LOW == 3'd1) || (A_LOW == 3'd2)) && !RW_n));

   always_comb begin
      bus_d      = bus_q;
      dout_d     = dout_q;
      cs_d       = cs_q;
      fast_d     = fast_q;
      div_d      = div_q;
      start_xfer = 1'b0;
      start_tx   = D_IN;
      case (bus_q)
         B_IDLE: if (start_cond) bus_d = B_WAIT;
         B_WAIT: begin
            if (as_s) bus_d = B_IDLE;
            else if (!eng_busy || !needs_idle) bus_d = B_EXEC;
         end
         B_EXEC: begin
            case (A_LOW)
               3'd0, 3'd3: dout_d = rx_q;
               3'd1:       dout_d = {eng_busy, !cd_s, 4'b0000, fast_q, cs_q};
               3'd2:       dout_d = div_q;
               default:    dout_d = '1;
            endcase
            if (!uds_s) begin
               if (!RW_n) begin
                  case (A_LOW)
                     3'd0:    start_xfer = 1'b1;
                     3'd1:    {fast_d, cs_d} = D_IN[1:0];
                     3'd2:    div_d = D_IN;
                     default: ;
                  endcase
               end else if (A_LOW == 3'd3) begin
                  start_xfer = 1'b1;
                  start_tx   = '1;
               end
            end
            bus_d = B_ACK;
         end
         B_ACK: if (as_s) bus_d = B_IDLE;
         default: bus_d = B_IDLE;
      endcase
   end

   always_comb begin
      eng_d   = eng_q;
      cnt_d   = cnt_q;
      bits_d  = bits_q;
      shift_d = shift_q;
      samp_d  = samp_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      rx_d    = rx_q;
      case (eng_q)
         E_IDLE: if (start_xfer) begin
            eng_d   = E_LOW;
            shift_d = start_tx;
            mosi_d  = start_tx[7];
            sclk_d  = 1'b0;
            cnt_d   = half_len;
            bits_d  = '0;
         end
         E_LOW: begin
            if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
            else if (bits_q == 4'd8) begin
               eng_d  = E_IDLE;
               rx_d   = shift_q;
               mosi_d = 1'b1;
               sclk_d = 1'b0;
            end else begin
               eng_d  = E_HIGH;
               sclk_d = 1'b1;
               samp_d = SD_MISO;
               bits_d = bits_q + 4'd1;
               cnt_d  = half_len;
            end
         end
         E_HIGH: begin
            if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
            else begin
               eng_d   = E_LOW;
               sclk_d  = 1'b0;
               shift_d = {shift_q[6:0], samp_q};
               mosi_d  = (bits_q == 4'd8) ? 1'b1 : shift_q[6];
               cnt_d   = half_len;
            end
         end
         default: eng_d = E_IDLE;
      endcase
   end

   always_ff @(posedge C50M or negedge RESET_n) begin
      if (!RESET_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
         bus_q   <= B_IDLE;
         eng_q   <= E_IDLE;
         dout_q  <= '1;
         div_q   <= 8'(DIV_RESET);
         rx_q    <= '1;
         shift_q <= '1;
         cnt_q   <= '0;
         bits_q  <= '0;
         cs_q    <= 1'b0;
         fast_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
         samp_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         bus_q   <= bus_d;
         eng_q   <= eng_d;
         dout_q  <= dout_d;
         div_q   <= div_d;
         rx_q    <= rx_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         bits_q  <= bits_d;
         cs_q    <= cs_d;
         fast_q  <= fast_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         samp_q  <= samp_d;
      end
   end

   // DTACK and the data enable follow the raw strobe so the bus is released at once.
   assign SDIO_DTACK_n = (bus_q == B_ACK) ? AS_CPU_n : 1'b1;
   assign D_OE         = (bus_q == B_ACK) && RW_n && !AS_CPU_n;
   assign D_OUT        = dout_q;
   assign SD_SCLK      = sclk_q;
   assign SD_MOSI      = mosi_q;
   assign SD_CS_n      = !cs_q;

endmodule

// File: tb/tb_sdio_spi_bridge.sv
// Directed bench for sdio_spi_bridge: bus-cycle stimulus with a read-data
// scoreboard checked by an independent DTACK monitor.
`timescale 1ns/1ps
module tb_sdio_spi_bridge;

   logic       C50M = 1'b0;
   logic       RESET_n = 1'b0;
   logic [7:0] A_HIGH = 8'hE9;
   logic [2:0] A_LOW = '0;
   logic       AS_CPU_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW_n = 1'b1;
   logic [7:0] D_IN = '0;
   logic [7:0] D_OUT;
   logic       D_OE;
   logic [7:0] BASE_SDIO = 8'hE9;
   logic       SDIO_CONFIGURED_n = 1'b0;
   logic       SDIO_ACCESS, SDIO_DTACK_n, SD_SCLK, SD_MOSI, SD_CS_n;
   logic       SD_MISO;
   logic       SD_CD_n = 1'b0;
   logic       miso_loop = 1'b1, miso_val = 1'b0;

   assign SD_MISO = miso_loop ? SD_MOSI : miso_val;

   sdio_spi_bridge #(.DIV_RESET(62), .SYNC_STAGES(2)) dut (
      .C50M(C50M), .RESET_n(RESET_n), .A_HIGH(A_HIGH), .A_LOW(A_LOW),
      .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW_n(RW_n),
      .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .BASE_SDIO(BASE_SDIO),
      .SDIO_CONFIGURED_n(SDIO_CONFIGURED_n), .SDIO_ACCESS(SDIO_ACCESS),
      .SDIO_DTACK_n(SDIO_DTACK_n), .SD_SCLK(SD_SCLK), .SD_MOSI(SD_MOSI),
      .SD_MISO(SD_MISO), .SD_CS_n(SD_CS_n), .SD_CD_n(SD_CD_n)
   );

   always #10 C50M = ~C50M;

   typedef struct {logic [7:0] data; int id;} exp_t;
   exp_t exp_q[$];
   int tests = 0;
   int fails = 0;
   int unsigned cyc = 0;
   int unsigned sclk_edges = 0;
   logic    mosi_bits[$];
   realtime rise_t[$];

   always @(posedge C50M) cyc++;
   always @(SD_SCLK) sclk_edges++;
   always @(posedge SD_SCLK) begin
      mosi_bits.push_back(SD_MOSI);
      rise_t.push_back($realtime);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every read acknowledge pops one expected byte.
   initial begin : monitor
      logic ack_seen;
      exp_t e;
      ack_seen = 1'b0;
      forever begin
         @(negedge C50M);
         if (!SDIO_DTACK_n && !ack_seen) begin
            ack_seen = 1'b1;
            if (D_OE) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_read: D_OUT=0x%02h with nothing expected", D_OUT);
               end else begin
                  e = exp_q.pop_front();
                  if (D_OUT !== e.data) begin
                     fails++;
                     $display("FAIL read#%0d: D_OUT=0x%02h expected 0x%02h", e.id, D_OUT, e.data);
                  end
               end
            end
         end else if (SDIO_DTACK_n) ack_seen = 1'b0;
      end
   end

   task automatic bus_cycle(input logic [2:0] idx, input logic rd, input logic [7:0] wdata,
                            input logic uds_on, input logic lds_on, input int unsigned budget,
                            output logic acked, output logic doe_seen, output int unsigned waited,
                            output int unsigned ack_cyc);
      @(negedge C50M);
      A_LOW = idx; RW_n = rd; D_IN = wdata;
      AS_CPU_n = 1'b0; UDS_n = !uds_on; LDS_n = !lds_on;
      acked = 1'b0; doe_seen = 1'b0; waited = 0; ack_cyc = 0;
      while (!acked && waited < budget) begin
         @(negedge C50M);
         waited++;
         if (D_OE) doe_seen = 1'b1;
         if (!SDIO_DTACK_n) begin
            acked = 1'b1;
            ack_cyc = cyc;
         end
      end
      @(negedge C50M);
      AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
      #1;
      if (acked) begin
         chk("dtack_release", {31'd0, SDIO_DTACK_n}, 32'd1);
         chk("doe_release", {31'd0, D_OE}, 32'd0);
      end
      repeat (4) @(negedge C50M);
   endtask

   task automatic rd(input logic [2:0] idx, input logic [7:0] exp, input int id);
      logic a, d;
      int unsigned w, c;
      exp_q.push_back('{data: exp, id: id});
      bus_cycle(idx, 1'b1, 8'h00, 1'b1, 1'b1, 3000, a, d, w, c);
      if (!a) $display("FAIL read_ack#%0d: no DTACK after %0d clocks, required within 3000", id, w);
      if (!a) fails++;
      tests++;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [7:0] data, input logic uds_on);
      logic a, d;
      int unsigned w, c;
      bus_cycle(idx, 1'b0, data, uds_on, 1'b1, 3000, a, d, w, c);
      chk("write_ack", {31'd0, a}, 32'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded 2 ms, required to finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic a, d;
      int unsigned w, c1, c2, mark, base;
      logic [7:0] b;
      logic ok;

      // 1: reset values and status
      repeat (5) @(negedge C50M);
      RESET_n = 1'b1;
      repeat (5) @(negedge C50M);
      chk("rst_cs_n", {31'd0, SD_CS_n}, 32'd1);
      chk("rst_sclk", {31'd0, SD_SCLK}, 32'd0);
      chk("rst_mosi", {31'd0, SD_MOSI}, 32'd1);
      chk("rst_dtack", {31'd0, SDIO_DTACK_n}, 32'd1);
      chk("rst_doe", {31'd0, D_OE}, 32'd0);
      chk("rst_dout", {24'd0, D_OUT}, 32'hFF);
      rd(3'd1, 8'h40, 1);
      rd(3'd2, 8'h3E, 2);
      rd(3'd5, 8'hFF, 3);
      wr(3'd1, 8'h01, 1'b0);
      rd(3'd1, 8'h40, 4);
      chk("lds_only_no_cs", {31'd0, SD_CS_n}, 32'd1);
      AS_CPU_n = 1'b0; #1;
      chk("access_hit", {31'd0, SDIO_ACCESS}, 32'd1);
      A_HIGH = 8'hE8; #1;
      chk("access_miss", {31'd0, SDIO_ACCESS}, 32'd0);
      AS_CPU_n = 1'b1; A_HIGH = 8'hE9;
      repeat (4) @(negedge C50M);

      // 2: unconfigured or wrong base never acknowledges
      SDIO_CONFIGURED_n = 1'b1;
      bus_cycle(3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1000, a, d, w, c1);
      chk("unconf_no_ack", {31'd0, a}, 32'd0);
      chk("unconf_no_doe", {31'd0, d}, 32'd0);
      SDIO_CONFIGURED_n = 1'b0;
      A_HIGH = 8'hEA;
      bus_cycle(3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 50, a, d, w, c1);
      chk("wrong_base_no_ack", {31'd0, a}, 32'd0);
      A_HIGH = 8'hE9;

      // 3: loopback 0xA5 with a one-clock half period
      wr(3'd1, 8'h01, 1'b1);
      chk("cs_asserted", {31'd0, SD_CS_n}, 32'd0);
      wr(3'd2, 8'h00, 1'b1);
      mark = mosi_bits.size();
      wr(3'd0, 8'hA5, 1'b1);
      repeat (40) @(negedge C50M);
      chk("a5_bit_count", mosi_bits.size() - mark, 32'd8);
      b = '0; ok = 1'b1;
      if (mosi_bits.size() >= mark + 8) begin
         for (int unsigned i = 0; i < 8; i++) b = {b[6:0], mosi_bits[mark+i]};
         for (int unsigned i = 0; i < 7; i++)
            if (rise_t[mark+i+1] - rise_t[mark+i] < 39.9 || rise_t[mark+i+1] - rise_t[mark+i] > 40.1) ok = 1'b0;
      end
      chk("a5_mosi_bits", {24'd0, b}, 32'hA5);
      chk("a5_sclk_40ns", {31'd0, ok}, 32'd1);
      chk("a5_sclk_idle", {31'd0, SD_SCLK}, 32'd0);
      chk("a5_mosi_idle", {31'd0, SD_MOSI}, 32'd1);
      rd(3'd0, 8'hA5, 5);

      // 4: second DATA write stalls for a full slow byte, status does not
      wr(3'd2, 8'd62, 1'b1);
      wr(3'd1, 8'h01, 1'b1);
      bus_cycle(3'd0, 1'b0, 8'h5A, 1'b1, 1'b1, 3000, a, d, w, c1);
      chk("w1_ack", {31'd0, a}, 32'd1);
      exp_q.push_back('{data: 8'hC1, id: 6});
      bus_cycle(3'd1, 1'b1, 8'h00, 1'b1, 1'b1, 3000, a, d, w, c2);
      chk("status_no_stall", {31'd0, (a && w < 12)}, 32'd1);
      bus_cycle(3'd0, 1'b0, 8'h81, 1'b1, 1'b1, 3000, a, d, w, c2);
      chk("w2_ack", {31'd0, a}, 32'd1);
      chk("w2_stalled", {31'd0, (c2 - c1 >= 1008)}, 32'd1);
      repeat (1300) @(negedge C50M);
      rd(3'd0, 8'h81, 7);

      // 5: XCHG streaming read with MISO low
      wr(3'd1, 8'h03, 1'b1);
      wr(3'd0, 8'h3C, 1'b1);
      repeat (40) @(negedge C50M);
      miso_loop = 1'b0; miso_val = 1'b0;
      mark = mosi_bits.size();
      rd(3'd3, 8'h3C, 8);
      repeat (60) @(negedge C50M);
      b = '0;
      if (mosi_bits.size() >= mark + 8)
         for (int unsigned i = 0; i < 8; i++) b = {b[6:0], mosi_bits[mark+i]};
      chk("xchg_mosi_ff", {24'd0, b}, 32'hFF);
      rd(3'd0, 8'h00, 9);
      wr(3'd3, 8'h55, 1'b1);
      rd(3'd0, 8'h00, 10);

      // 6: reset at the 4th SCLK edge
      miso_loop = 1'b1;
      wr(3'd1, 8'h01, 1'b1);
      wr(3'd2, 8'h03, 1'b1);
      base = sclk_edges;
      wr(3'd0, 8'h96, 1'b1);
      w = 0;
      while (sclk_edges - base < 4 && w < 400) begin
         @(negedge C50M);
         w++;
      end
      chk("saw_4_edges", sclk_edges - base, 32'd4);
      RESET_n = 1'b0;
      #1;
      chk("mid_rst_cs_n", {31'd0, SD_CS_n}, 32'd1);
      chk("mid_rst_sclk", {31'd0, SD_SCLK}, 32'd0);
      chk("mid_rst_mosi", {31'd0, SD_MOSI}, 32'd1);
      chk("mid_rst_dtack", {31'd0, SDIO_DTACK_n}, 32'd1);
      chk("mid_rst_doe", {31'd0, D_OE}, 32'd0);
      @(negedge C50M);
      RESET_n = 1'b1;
      repeat (4) @(negedge C50M);
      rd(3'd0, 8'hFF, 11);
      rd(3'd2, 8'h3E, 12);
      rd(3'd1, 8'h40, 13);

      repeat (5) @(negedge C50M);
      chk("scoreboard_drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
